// File: rtl/acc_ctrl_if.sv
// Operand stream and accumulator-core bus between the source, acc_ctrl and the core.
// Latency: none (wires only).
// Backpressure: the operand stream uses valid/ready; the core side has no backpressure.
//
// Modports:
//   slave  - the controller side (acc_ctrl): takes operands and core result, drives core controls.
//   master - the environment side: operand source plus accumulator core.
interface acc_ctrl_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 32
);
    logic                     in_valid_i;
    logic [IN_DATA_WIDTH-1:0] in_data_i;
    logic                     in_ready_o;
    logic                     core_run_o;
    logic                     core_valid_o;
    logic [IN_DATA_WIDTH-1:0] core_number_o;
    logic [DWIDTH-1:0]        core_result_i;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  core_result_i,
        output in_ready_o,
        output core_run_o,
        output core_valid_o,
        output core_number_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output core_result_i,
        input  in_ready_o,
        input  core_run_o,
        input  core_valid_o,
        input  core_number_o
    );
endinterface

// File: rtl/acc_ctrl.sv
// Sequencing controller for the accumulator core: clear, feed N operands, drain, report sum.
// Latency: start in cycle 0, done_o in cycle N+4 with a stall-free operand stream.
// Backpressure: in_ready_o high only while operands are still owed; in_valid_i stalls extend ACCUM.
//
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   start_i, cnt_i    start command and element count, sampled only in IDLE
//   bus (slave)       operand stream in, core run/valid/number out, core result in
//   busy_o            high in every state except IDLE
//   done_o, result_o  one-cycle done pulse; result held until the next capture
//   abort_i           only when ACC_CTRL_ABORT_EN is defined: returns to IDLE without done
module acc_ctrl #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    acc_ctrl_if.slave            bus,
`ifdef ACC_CTRL_ABORT_EN
    input  logic                 abort_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DWIDTH-1:0]    result_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t                   state;
    logic [CNT_WIDTH-1:0]     remaining;
    logic                     drain_cnt;
    logic                     in_ready_q;
    logic                     core_run_q;
    logic                     core_valid_q;
    logic [IN_DATA_WIDTH-1:0] core_number_q;
    logic                     abort_req;
    logic                     hs;

`ifdef ACC_CTRL_ABORT_EN
    // Abort only matters outside IDLE; in IDLE a start still wins.
    assign abort_req = abort_i && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // Abort masks ready in its own cycle so no operand is swallowed by an aborted run.
    assign bus.in_ready_o    = in_ready_q && !abort_req;
    assign hs                = bus.in_valid_i && bus.in_ready_o;
    assign bus.core_run_o    = core_run_q;
    assign bus.core_valid_o  = core_valid_q;
    assign bus.core_number_o = core_number_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            remaining     <= '0;
            drain_cnt     <= 1'b0;
            in_ready_q    <= 1'b0;
            core_run_q    <= 1'b0;
            core_valid_q  <= 1'b0;
            core_number_q <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            result_o      <= '0;
        end else if (abort_req) begin
            state        <= IDLE;
            remaining    <= '0;
            drain_cnt    <= 1'b0;
            in_ready_q   <= 1'b0;
            core_run_q   <= 1'b0;
            core_valid_q <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_valid_q <= 1'b0;
                    done_o       <= 1'b0;
                    if (start_i) begin
                        remaining  <= cnt_i;
                        core_run_q <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    core_run_q <= 1'b0;
                    if (remaining != '0) begin
                        in_ready_q <= 1'b1;
                        state      <= ACCUM;
                    end else begin
                        state <= DRAIN;
                    end
                end
                ACCUM: begin
                    core_valid_q <= hs;
                    if (hs) begin
                        core_number_q <= bus.in_data_i;
                        remaining     <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            in_ready_q <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // First cycle: core sees the last operand. Second: core result is final.
                    core_valid_q <= 1'b0;
                    if (!drain_cnt) begin
                        drain_cnt <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b0;
                        result_o  <= bus.core_result_i;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_ctrl.sv
module tb_acc_ctrl;
    localparam int IW = 8;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic [CW-1:0] cnt_i;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] result_o;
`ifdef ACC_CTRL_ABORT_EN
    logic          abort_i;
`endif

    always #5 clk = ~clk;

    acc_ctrl_if #(.IN_DATA_WIDTH(IW), .DWIDTH(DW)) bus ();

    acc_ctrl #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .cnt_i    (cnt_i),
        .bus      (bus.slave),
`ifdef ACC_CTRL_ABORT_EN
        .abort_i  (abort_i),
`endif
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // Accumulator core: clears on run, adds each valid operand, one register of latency.
    logic [DW-1:0] core_sum;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              core_sum <= '0;
        else if (bus.core_run_o)   core_sum <= '0;
        else if (bus.core_valid_o) core_sum <= core_sum + DW'(bus.core_number_o);
    end
    assign bus.core_result_i = core_sum;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: outputs derived from the cycle offset since start and the handshakes seen.
    bit            m_active = 1'b0;
    int            m_k = 0;
    int            m_n = 0;
    int            m_acc = 0;
    int            m_end = -1;
    logic [DW-1:0] m_sum = '0;
    logic [DW-1:0] m_res = '0;
    logic [IW-1:0] m_num = '0;
    bit            m_prev_hs = 1'b0;
    bit            e_ready, e_run, e_busy, e_done, m_hs, m_ab;

    always @(negedge clk) begin
        m_ab = 1'b0;
`ifdef ACC_CTRL_ABORT_EN
        m_ab = abort_i;
`endif
        if (!reset_n) begin
            m_active  = 1'b0;
            m_prev_hs = 1'b0;
            m_num     = '0;
            m_res     = '0;
            chk("rst_in_ready", bus.in_ready_o, 0);
            chk("rst_core_run", bus.core_run_o, 0);
            chk("rst_core_valid", bus.core_valid_o, 0);
            chk("rst_core_number", bus.core_number_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_result", result_o, 0);
        end else begin
            e_busy  = m_active;
            e_run   = m_active && (m_k == 1);
            e_ready = m_active && (m_k >= 2) && (m_acc < m_n) && !m_ab;
            e_done  = m_active && (m_k == m_end);
            if (e_done) m_res = m_sum;
            chk("in_ready", bus.in_ready_o, e_ready);
            chk("core_run", bus.core_run_o, e_run);
            chk("core_valid", bus.core_valid_o, m_prev_hs);
            chk("core_number", bus.core_number_o, m_num);
            chk("busy", busy_o, e_busy);
            chk("done", done_o, e_done);
            chk("result", result_o, m_res);

            m_hs = e_ready && bus.in_valid_i;
            if (!m_active) begin
                m_prev_hs = 1'b0;
                if (start_i) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_n      = int'(cnt_i);
                    m_acc    = 0;
                    m_sum    = '0;
                    m_end    = (cnt_i == 0) ? 4 : -1;
                end
            end else if (m_ab) begin
                m_active  = 1'b0;
                m_prev_hs = 1'b0;
            end else begin
                if (m_hs) begin
                    m_acc++;
                    m_sum = m_sum + DW'(bus.in_data_i);
                    m_num = bus.in_data_i;
                    if (m_acc == m_n) m_end = m_k + 3;
                end
                m_prev_hs = m_hs;
                if (m_k == m_end) m_active = 1'b0;
                m_k++;
            end
        end
    end

    // Runs one transaction starting at the next rising edge; returns the cycle offset of done_o.
    task automatic run_txn(input int n, input int pct, input int gap, input bit glitch,
                           input logic [IW-1:0] ops[$], output int done_cyc, output logic [DW-1:0] res);
        int idx = 0;
        int gl  = 0;
        int cyc = 0;
        bit got = 1'b0;
        done_cyc = -1;
        res      = '0;
        @(posedge clk); #1;
        start_i = 1'b1;
        cnt_i   = CW'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
        cnt_i   = CW'($urandom);
        cyc     = 1;
        while (!got && cyc < 2000) begin
            start_i        = glitch && (cyc == 3);
            bus.in_valid_i = (gl == 0) && ($urandom_range(99) < pct);
            bus.in_data_i  = (idx < ops.size()) ? ops[idx] : IW'($urandom);
            @(negedge clk);
            if (done_o) begin
                got      = 1'b1;
                done_cyc = cyc;
                res      = result_o;
            end else if (bus.in_valid_i && bus.in_ready_o) begin
                idx++;
                gl = gap;
            end else if (gl > 0) begin
                gl--;
            end
            if (!got) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.in_valid_i = 1'b0;
        start_i        = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    logic [IW-1:0] q[$];
    int            dc;
    logic [DW-1:0] r;
    logic [DW-1:0] exp_sum;
    int            n;

    initial begin
        reset_n        = 1'b0;
        start_i        = 1'b0;
        cnt_i          = '0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
`ifdef ACC_CTRL_ABORT_EN
        abort_i        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        q = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_txn(4, 100, 0, 1'b0, q, dc, r);
        chk("t1_done_cycle", dc, 8);
        chk("t1_result", r, 10);

        q = '{8'd5, 8'd6, 8'd7};
        run_txn(3, 100, 2, 1'b0, q, dc, r);
        chk("t2_done_cycle", dc, 11);
        chk("t2_result", r, 18);

        q = {};
        run_txn(0, 100, 0, 1'b0, q, dc, r);
        chk("t3_done_cycle", dc, 4);
        chk("t3_result", r, 0);

        q = '{8'd200, 8'd100};
        run_txn(2, 100, 0, 1'b1, q, dc, r);
        chk("t4_done_cycle", dc, 6);
        chk("t4_wrap_result", r, 44);

        // Reset after two of five operands have been accepted.
        @(posedge clk); #1;
        start_i = 1'b1;
        cnt_i   = 16'd5;
        @(posedge clk); #1;
        start_i        = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'd1;
        @(posedge clk); #1;
        bus.in_data_i  = 8'd1;
        @(posedge clk); #1;
        bus.in_data_i  = 8'd2;
        @(posedge clk); #1;
        reset_n        = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_reset", busy_o, 0);
        chk("t5_result_after_reset", result_o, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        q = '{8'd9};
        run_txn(1, 100, 0, 1'b0, q, dc, r);
        chk("t5_done_cycle", dc, 5);
        chk("t5_result", r, 9);

`ifdef ACC_CTRL_ABORT_EN
        // Abort in the first DRAIN cycle of an N=3 run.
        @(posedge clk); #1;
        start_i = 1'b1;
        cnt_i   = 16'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = IW'(8 + c);
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        abort_i        = 1'b1;
        @(negedge clk);
        chk("ab_busy_in_abort_cycle", busy_o, 1);
        @(posedge clk); #1 abort_i = 1'b0;
        @(negedge clk);
        chk("ab_busy_after", busy_o, 0);
        chk("ab_result_kept", result_o, 9);
        repeat (4) begin
            @(negedge clk);
            chk("ab_no_done", done_o, 0);
        end
        q = '{8'd3, 8'd4};
        run_txn(2, 100, 0, 1'b0, q, dc, r);
        chk("ab_next_done_cycle", dc, 6);
        chk("ab_next_result", r, 7);
`endif

        repeat (30) begin
            n = $urandom_range(0, 12);
            q = {};
            exp_sum = '0;
            for (int i = 0; i < n; i++) begin
                q.push_back(IW'($urandom));
                exp_sum = exp_sum + DW'(q[i]);
            end
            run_txn(n, $urandom_range(25, 100), $urandom_range(0, 1), 1'($urandom_range(0, 1)), q, dc, r);
            chk("rnd_result", r, exp_sum);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
